// File: rtl/mux_arb_pkg.sv
// Shared definitions for the four-way round-robin output arbiter:
// requester count, select width, FSM state encoding and the round-robin pick.
package mux_arb_pkg;

    localparam int N_REQ = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    // Scans from lowest to highest priority so the highest-priority hit is written last.
    function automatic logic [SEL_W-1:0] rr_next(input logic [N_REQ-1:0] valid,
                                                 input logic [SEL_W-1:0] last);
        logic [SEL_W-1:0] idx;
        rr_next = last;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = last + SEL_W'(k);
            if (valid[idx]) rr_next = idx;
        end
    endfunction

endpackage

// File: rtl/mux_4to1.sv
// Plain combinational 4:1 data select used by the arbiter datapath.
module mux_4to1 #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic [1:0]       sel,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        case (sel)
            2'd0:    y = a;
            2'd1:    y = b;
            2'd2:    y = c;
            default: y = d;
        endcase
    end

endmodule

// File: rtl/mux_4to1_rr_arbiter.sv
// Round-robin arbiter sharing one registered output channel among four requesters.
// Optional grant retention (lock port, LOCKED state) is enabled by MUX_ARB_LOCK_EN.
module mux_4to1_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
`ifdef MUX_ARB_LOCK_EN
    input  logic [N_REQ-1:0] lock,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic [N_REQ-1:0] req_valid,
    output logic [N_REQ-1:0] req_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SEL_W-1:0] grant_sel
);

    logic [WIDTH-1:0] data_p1;
    logic             vld_p1;
    logic [SEL_W-1:0] sel_p1;
    logic [SEL_W-1:0] last;
    logic [SEL_W-1:0] win;
    logic [WIDTH-1:0] mux_y;
    logic             can_load;
    logic             grant;

`ifdef MUX_ARB_LOCK_EN
    arb_state_t state;
`endif

    always_comb begin
        can_load = !vld_p1 || out_ready;
        win      = rr_next(req_valid, last);
        grant    = can_load && (|req_valid) && !rst;
`ifdef MUX_ARB_LOCK_EN
        // While locked the pointer is frozen on the owner, so it doubles as the owner index.
        if (state == LOCKED) begin
            win   = last;
            grant = can_load && req_valid[last] && !rst;
        end
`endif
        req_ready = '0;
        if (grant) req_ready[win] = 1'b1;
    end

    mux_4to1 #(.WIDTH(WIDTH)) u_mux (
        .a   (a),
        .b   (b),
        .c   (c),
        .d   (d),
        .sel (win),
        .y   (mux_y)
    );

    // p0 -> p1: winner's beat captured into the output register
    always_ff @(posedge clk) begin
        if (rst) begin
            data_p1 <= '0;
            vld_p1  <= 1'b0;
            sel_p1  <= '0;
            last    <= '1;
`ifdef MUX_ARB_LOCK_EN
            state   <= ARB;
`endif
        end else begin
            if (grant) begin
                data_p1 <= mux_y;
                vld_p1  <= 1'b1;
                sel_p1  <= win;
            end else if (can_load) begin
                vld_p1  <= 1'b0;
            end
`ifdef MUX_ARB_LOCK_EN
            case (state)
                ARB: begin
                    if (grant) begin
                        last <= win;
                        if (lock[win]) state <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (can_load && !req_valid[last]) state <= ARB;
                    else if (grant && !lock[last])    state <= ARB;
                end
                default: state <= ARB;
            endcase
`else
            if (grant) last <= win;
`endif
        end
    end

    assign out_data  = data_p1;
    assign out_valid = vld_p1;
    assign grant_sel = sel_p1;

endmodule

// File: doc/mux_4to1_rr_arbiter.md
# mux_4to1_rr_arbiter

- Shares one WIDTH-bit output channel among four valid/ready requesters (a, b, c, d).
- Arbitration is round-robin. The existing `mux_4to1` datapath steers the winner's data into a single registered output stage.
- Sits between four producer blocks and one downstream consumer. It sequences the mux select so software-visible lab datapaths can be time-shared without combinational select glitches.

## Interface
- `WIDTH`, default 8, data width of every requester and of the output.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset. One clock; reset is synchronous and active-high.
- `a`, `b`, `c`, `d`  in  WIDTH each  requester data buses 0..3.
- `req_valid`  in  4  bit i is high when requester i presents a beat.
- `req_ready`  out  4  bit i high means requester i's beat is accepted this cycle. At most one bit is high.
- `out_data`  out  WIDTH  registered selected beat.
- `out_valid`  out  1  out_data holds an undelivered beat.
- `out_ready`  in  1  consumer accepts out_data when high together with out_valid.
- `grant_sel`  out  2  index of the requester whose beat currently sits in out_data.
- `lock`  in  4  present only with `MUX_ARB_LOCK_EN`: bit i requests grant retention for requester i.

## Operation
- **Output stage.** One register holding out_data, out_valid and grant_sel.
  - The stage can load when `!out_valid || out_ready`.
- **Pointer.** A 2-bit `last` pointer holds the index of the most recent winner.
  - Priority order is last+1, last+2, last+3, last, all modulo 4.
  - Wrap-around: last=3 → order 0,1,2,3.
- **ARB state.**
  - If the stage can load and any req_valid bit is set, the highest-priority valid requester i wins.
  - req_ready[i]=1, all other ready bits are 0.
  - On the clock edge: out_data ← mux_4to1(a,b,c,d,sel=i), out_valid ← 1, grant_sel ← i, last ← i.
- **Stage cannot load** (out_valid && !out_ready): all req_ready = 0 and the register holds its contents.
- **No valid requests while the stage can load:** out_valid ← 0 once the held beat drains; last is unchanged.
- **Simultaneous drain and accept:** permitted in the same cycle, giving 1 beat/cycle throughput.
- **Fairness:** every requester that stays valid is granted within 4 accepted beats.
- **Request withdrawal:** a requester dropping req_valid before being granted loses nothing, and the pointer does not advance.

## Timing
- **Reset values:** out_valid=0, out_data=0, grant_sel=0, last=3 (requester 0 has first priority), req_ready=0, FSM=ARB.
- **req_ready** is combinational from req_valid, last, out_valid, out_ready and FSM state. It is never asserted while rst=1.
- **Latency:** 1 cycle from the accepting edge to the beat on out_data/out_valid.
- **Back-pressure:** with out_ready low, out_data and grant_sel are stable for as long as out_valid=1.
- **Reset mid-operation:** any beat in the output register is discarded and the pointer returns to 3.

## Configuration
- **`MUX_ARB_LOCK_EN` defined:**
  - Adds the `lock` port and a LOCKED FSM state.
  - Winner i with lock[i]=1 moves to LOCKED.
  - In LOCKED only requester i can be granted, and last is frozen.
  - LOCKED returns to ARB when a beat from i is accepted with lock[i]=0, or when req_valid[i]=0 while the stage can load.
  - Other requesters wait. Fairness resumes after release.
- **`MUX_ARB_LOCK_EN` undefined:** no lock port and no LOCKED state. The FSM stays in ARB and the arbiter is pure round-robin per beat.

## Structure
- **Package `mux_arb_pkg`:**
  - `N_REQ` = 4 and `SEL_W` = 2.
  - The FSM state enum (ARB, LOCKED).
  - A `rr_next` function returning the winner index from the valid vector and last.
- **Sub-module:** one instance of the existing `mux_4to1 #(WIDTH)` for the data select. The arbiter drives its sel with the combinational winner index.

## Test plan
- **Single requester:** reset, then req_valid=4'b0100, c=8'hCC, out_ready=1.
  - req_ready=4'b0100 the same cycle.
  - Next cycle out_valid=1, out_data=8'hCC, grant_sel=2.
- **All four continuously valid:** a..d = AA/BB/CC/DD, out_ready=1.
  - out_data sequence AA,BB,CC,DD,AA…, one beat per cycle.
  - Exactly one req_ready bit high each cycle.
- **Back-pressure:** all valid, out_ready=0 for 5 cycles after the first beat.
  - out_data holds AA, req_ready=0.
  - Releasing out_ready resumes with BB.
- **Pointer wrap and skip:** last=3, req_valid=4'b1010.
  - Grants 1 then 3 then 1.
  - Dropping req_valid[1] mid-wait gives 3 repeatedly, with no stall cycles.
- **Reset mid-operation:** rst pulsed while out_valid=1 with DD held.
  - Next cycle out_valid=0, out_data=0, and the first grant afterwards goes to requester 0.
- **Lock (`MUX_ARB_LOCK_EN` only):** all valid, lock=4'b0010.
  - Requester 1 wins every beat (BB,BB,BB).
  - After lock[1] drops, the next grant after a final BB goes to requester 2 (CC).
